sqrt_unit_param: RTL and testbench



---
 rtl/sqrt_unit_param_if.sv | 16 +
 rtl/sqrt_unit_param.sv | 111 +++++++++++
 tb/tb_sqrt_unit_param.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/sqrt_unit_param_if.sv
// rtl/sqrt_unit_param_if.sv - St/done handshake and result bundle for the square-root unit
interface sqrt_unit_param_if #(
   parameter int WIDTH = 8
);
   localparam int R = WIDTH / 2;

   logic             St;
   logic [WIDTH-1:0] N;
   logic             busy;
   logic             done;
   logic [R-1:0]     sqrt;
   logic [R:0]       rem;

   modport master (output St, N, input busy, done, sqrt, rem);
   modport slave  (input St, N, output busy, done, sqrt, rem);
endinterface

// File: rtl/sqrt_unit_param.sv
// rtl/sqrt_unit_param.sv - restoring digit-by-digit integer square root, one root bit per clock
module sqrt_unit_param #(
   parameter int WIDTH = 8
) (
   input logic               clk,
   input logic               rst,
   sqrt_unit_param_if.slave  bus
);
   localparam int R  = WIDTH / 2;
   localparam int CW = (R > 1) ? $clog2(R) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(R - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] op_q, op_d;
   logic [R-1:0]     q_q, q_d;
   logic [R+1:0]     r_q, r_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [R-1:0]     sqrt_q, sqrt_d;
   logic [R:0]       rem_q, rem_d;
   logic             busy_q, done_q;

   logic [R+1:0]     r_shift;
   logic [R+2:0]     trial;
   logic             take;
   logic [R:0]       q_ext;
   logic [R-1:0]     q_next;
   logic [R+1:0]     r_next;

   // One extra bit on the trial subtraction makes its top bit a clean sign.
   always_comb begin
      r_shift = {r_q[R-1:0], op_q[WIDTH-1 -: 2]};
      trial   = {1'b0, r_shift} - {1'b0, q_q, 2'b01};
      take    = ~trial[R+2];
      q_ext   = {q_q, take};
      q_next  = q_ext[R-1:0];
      r_next  = take ? trial[R+1:0] : r_shift;
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      q_d     = q_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      sqrt_d  = sqrt_q;
      rem_d   = rem_q;
      case (state_q)
         IDLE: begin
            if (bus.St) begin
               op_d    = bus.N;
               q_d     = '0;
               r_d     = '0;
               cnt_d   = CNT_LOAD;
               state_d = CALC;
            end
         end
         CALC: begin
            op_d  = op_q << 2;
            q_d   = q_next;
            r_d   = r_next;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               sqrt_d  = q_next;
               rem_d   = r_next[R:0];
               state_d = DONE;
            end
         end
         DONE: begin
            if (!bus.St) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= '0;
         q_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         sqrt_q  <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         q_q     <= q_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         sqrt_q  <= sqrt_d;
         rem_q   <= rem_d;
         busy_q  <= (state_d == CALC);
         done_q  <= (state_d == DONE);
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sqrt = sqrt_q;
   assign bus.rem  = rem_q;
endmodule

// File: tb/tb_sqrt_unit_param.sv
// tb/tb_sqrt_unit_param.sv - directed bench for the square-root unit at WIDTH 8 and 16
module tb_sqrt_unit_param;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   sqrt_unit_param_if #(.WIDTH(8))  b8 ();
   sqrt_unit_param_if #(.WIDTH(16)) b16 ();

   sqrt_unit_param #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));
   sqrt_unit_param #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Starts one operation, waits (bounded) for done, captures the result, then drops St.
   task automatic run_op(input int w, input int n, output int s, output int r,
                         output int lat, output int bcnt, output int ovl);
      bit d;
      bit b;
      lat  = 0;
      bcnt = 0;
      ovl  = 0;
      d    = 1'b0;
      if (w == 8) begin
         b8.St = 1'b1;
         b8.N  = 8'(n);
      end else begin
         b16.St = 1'b1;
         b16.N  = 16'(n);
      end
      while (!d && lat < 40) begin
         @(negedge clk);
         lat++;
         if (w == 8) begin
            d = b8.done;
            b = b8.busy;
         end else begin
            d = b16.done;
            b = b16.busy;
         end
         if (b) bcnt++;
         if (b && d) ovl = 1;
      end
      if (w == 8) begin
         s = int'(b8.sqrt);
         r = int'(b8.rem);
         b8.St = 1'b0;
      end else begin
         s = int'(b16.sqrt);
         r = int'(b16.rem);
         b16.St = 1'b0;
      end
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int s, r, lat, bc, ovl, es, dc;
      checks = 0;
      errors = 0;
      b8.St  = 1'b0;
      b8.N   = '0;
      b16.St = 1'b0;
      b16.N  = '0;
      rst    = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy8", b8.busy, 0);
      check("rst_done8", b8.done, 0);
      check("rst_sqrt8", b8.sqrt, 0);
      check("rst_rem8", b8.rem, 0);
      check("rst_busy16", b16.busy, 0);
      check("rst_sqrt16", b16.sqrt, 0);

      run_op(8, 0, s, r, lat, bc, ovl);
      check("n0_latency", lat, 5);
      check("n0_sqrt", s, 0);
      check("n0_rem", r, 0);
      check("n0_busy_cycles", bc, 4);
      check("n0_done_drop", b8.done, 0);

      run_op(8, 144, s, r, lat, bc, ovl);
      check("n144_sqrt", s, 12);
      check("n144_rem", r, 0);

      run_op(8, 255, s, r, lat, bc, ovl);
      check("n255_sqrt", s, 15);
      check("n255_rem", r, 30);
      check("n255_persist_sqrt", b8.sqrt, 15);

      for (int n = 0; n < 256; n++) begin
         es = 0;
         while ((es + 1) * (es + 1) <= n) es++;
         run_op(8, n, s, r, lat, bc, ovl);
         check("sweep_sqrt", s, es);
         check("sweep_identity", s * s + r, n);
         check("sweep_rem_bound", (r <= 2 * s), 1);
         check("sweep_busy_cycles", bc, 4);
         check("sweep_latency", lat, 5);
         check("sweep_busy_done_overlap", ovl, 0);
      end

      run_op(16, 65535, s, r, lat, bc, ovl);
      check("w16_max_latency", lat, 9);
      check("w16_max_sqrt", s, 255);
      check("w16_max_rem", r, 510);
      check("w16_max_busy_cycles", bc, 8);
      run_op(16, 65025, s, r, lat, bc, ovl);
      check("w16_sq_sqrt", s, 255);
      check("w16_sq_rem", r, 0);
      run_op(16, 1, s, r, lat, bc, ovl);
      check("w16_one_sqrt", s, 1);
      check("w16_one_rem", r, 0);

      b8.St = 1'b1;
      b8.N  = 8'd100;
      dc = 0;
      bc = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (b8.done) dc++;
         if (b8.busy) bc++;
      end
      check("hold_busy_cycles", bc, 4);
      check("hold_done_cycles", dc, 16);
      check("hold_sqrt", b8.sqrt, 10);
      check("hold_rem", b8.rem, 0);
      b8.St = 1'b0;
      @(negedge clk);
      check("drop_done", b8.done, 0);
      check("drop_busy", b8.busy, 0);
      repeat (3) @(negedge clk);
      check("idle_sqrt_persist", b8.sqrt, 10);

      b8.St = 1'b1;
      b8.N  = 8'd77;
      @(negedge clk);
      b8.St = 1'b0;
      b8.N  = 8'd255;
      @(negedge clk);
      b8.St = 1'b1;
      b8.N  = 8'd3;
      @(negedge clk);
      b8.St = 1'b0;
      repeat (2) @(negedge clk);
      check("toggle_done", b8.done, 1);
      check("toggle_sqrt", b8.sqrt, 8);
      check("toggle_rem", b8.rem, 13);
      @(negedge clk);
      check("toggle_back_idle", b8.done, 0);

      b8.St = 1'b1;
      b8.N  = 8'd200;
      repeat (3) @(negedge clk);
      check("mid_busy_before_rst", b8.busy, 1);
      rst   = 1'b1;
      b8.St = 1'b0;
      #1;
      check("mid_rst_busy", b8.busy, 0);
      check("mid_rst_done", b8.done, 0);
      check("mid_rst_sqrt", b8.sqrt, 0);
      check("mid_rst_rem", b8.rem, 0);
      check("mid_rst_sqrt16", b16.sqrt, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_op(8, 49, s, r, lat, bc, ovl);
      check("post_rst_latency", lat, 5);
      check("post_rst_sqrt", s, 7);
      check("post_rst_rem", r, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
